// File: rtl/bb_uart_txq_pkg.sv
// Shared definitions for the bb_uart transmitter (and the future receiver).
package bb_uart_txq_pkg;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_ODD  = 1;
    localparam int unsigned PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAR   = 3'd3,
        ST_STOP  = 3'd4
    } tx_state_e;

    // Parity of a character zero-extended to 8 bits (zero padding leaves XOR unchanged).
    function automatic logic parity_bit(input logic [7:0] data, input int unsigned mode);
        return (mode == PARITY_ODD) ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/bb_uart_txq_if.sv
// Write port and line/status signals of the buffered UART transmitter.
interface bb_uart_txq_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 wr_en;
    logic [DATA_BITS-1:0] wr_data;
    logic                 full;
    logic                 empty;
    logic                 ovf;
    logic                 txd;
    logic                 txbsy;
    logic                 bd_tick;

    modport master (
        output wr_en, wr_data,
        input  full, empty, ovf, txd, txbsy, bd_tick
    );

    modport slave (
        input  wr_en, wr_data,
        output full, empty, ovf, txd, txbsy, bd_tick
    );
endinterface

// File: rtl/bb_uart_txq_baudgen.sv
// Bit-time divider: counts 0..CLK_DIVIDER-1 while enabled, ticks on the last count.
module bb_uart_baudgen #(
    parameter int unsigned CLK_DIVIDER = 521
) (
    input  logic clk,
    input  logic nrst,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int unsigned CNT_W = (CLK_DIVIDER > 1) ? $clog2(CLK_DIVIDER) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIVIDER - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: clear wins, otherwise wrap at CNT_MAX while enabled
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && (cnt_q == CNT_MAX);

endmodule

// File: rtl/bb_uart_txq.sv
// Buffered UART transmitter: write FIFO feeding a framing FSM with configurable
// data width, parity and stop bits; back-to-back frames leave no idle gap.
module bb_uart_txq
    import bb_uart_txq_pkg::*;
#(
    parameter int unsigned CLK_DIVIDER = 521,
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned PARITY      = 0,
    parameter int unsigned STOP_BITS   = 1,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic           clk,
    input  logic           nrst,
    bb_uart_txq_if.slave   bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned BIT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(FIFO_DEPTH);
    localparam logic [BIT_W-1:0] LAST_BIT_C = BIT_W'(DATA_BITS - 1);
    localparam logic             LAST_STOP_C = 1'(STOP_BITS - 1);

    // FIFO state
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 full_q, full_d;
    logic                 empty_q, empty_d;
    logic                 ovf_q, ovf_d;
    logic                 push;
    logic                 pop;
    logic [DATA_BITS-1:0] head;

    // Framing state
    tx_state_e            state_q, state_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_q, par_d;
    logic [BIT_W-1:0]     bitcnt_q, bitcnt_d;
    logic                 stopcnt_q, stopcnt_d;
    logic                 txd_q, txd_d;
    logic                 txbsy_q, txbsy_d;
    logic                 start_frame;
    logic                 tick;

    assign push = bus.wr_en && !full_q;
    assign head = mem_q[rd_ptr_q];

    bb_uart_baudgen #(
        .CLK_DIVIDER (CLK_DIVIDER)
    ) u_baudgen (
        .clk  (clk),
        .nrst (nrst),
        .en   (state_q != ST_IDLE),
        .clr  (pop),
        .tick (tick)
    );

    // FIFO pointer/count/flag update; full is the pre-edge value so a write into a full FIFO drops
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        full_d   = (count_d == DEPTH_C);
        empty_d  = (count_d == '0);
        ovf_d    = ovf_q | (bus.wr_en & full_q);
    end

    // FIFO storage, no reset needed since entries are only read after being written
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.wr_data;
        end
    end

    // Framing FSM next state and registered line outputs
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        par_d       = par_q;
        bitcnt_d    = bitcnt_q;
        stopcnt_d   = stopcnt_q;
        txd_d       = txd_q;
        txbsy_d     = txbsy_q;
        start_frame = 1'b0;
        pop         = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!empty_q) begin
                    start_frame = 1'b1;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d  = ST_DATA;
                    txd_d    = shreg_q[0];
                    shreg_d  = shreg_q >> 1;
                    bitcnt_d = '0;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bitcnt_q == LAST_BIT_C) begin
                        if (PARITY != PARITY_NONE) begin
                            state_d = ST_PAR;
                            txd_d   = par_q;
                        end else begin
                            state_d   = ST_STOP;
                            txd_d     = 1'b1;
                            stopcnt_d = 1'b0;
                        end
                    end else begin
                        txd_d    = shreg_q[0];
                        shreg_d  = shreg_q >> 1;
                        bitcnt_d = bitcnt_q + BIT_W'(1);
                    end
                end
            end
            ST_PAR: begin
                if (tick) begin
                    state_d   = ST_STOP;
                    txd_d     = 1'b1;
                    stopcnt_d = 1'b0;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (stopcnt_q == LAST_STOP_C) begin
                        if (!empty_q) begin
                            start_frame = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            txd_d   = 1'b1;
                            txbsy_d = 1'b0;
                        end
                    end else begin
                        stopcnt_d = stopcnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                txd_d   = 1'b1;
                txbsy_d = 1'b0;
            end
        endcase

        // Frame start: pop the head, latch its parity and drive the start bit
        if (start_frame) begin
            pop     = 1'b1;
            shreg_d = head;
            par_d   = parity_bit(8'(head), PARITY);
            state_d = ST_START;
            txd_d   = 1'b0;
            txbsy_d = 1'b1;
        end
    end

    // State registers for FIFO control and framing
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            ovf_q     <= 1'b0;
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            par_q     <= 1'b0;
            bitcnt_q  <= '0;
            stopcnt_q <= 1'b0;
            txd_q     <= 1'b1;
            txbsy_q   <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            ovf_q     <= ovf_d;
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            par_q     <= par_d;
            bitcnt_q  <= bitcnt_d;
            stopcnt_q <= stopcnt_d;
            txd_q     <= txd_d;
            txbsy_q   <= txbsy_d;
        end
    end

    assign bus.full    = full_q;
    assign bus.empty   = empty_q;
    assign bus.ovf     = ovf_q;
    assign bus.txd     = txd_q;
    assign bus.txbsy   = txbsy_q;
    assign bus.bd_tick = tick;

endmodule

// File: tb/tb_bb_uart_txq.sv
// Bench for bb_uart_txq: four configurations (8N1, 8E1, 8O1, 7N2) at CLK_DIVIDER=4,
// expected frames queued on write and compared bit by bit as they leave txd.
module tb_bb_uart_txq;

    localparam int unsigned DIV = 4;

    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    logic [3:0] wr_en_v;
    logic [7:0] wr_data_v [4];

    bb_uart_txq_if #(.DATA_BITS(8)) if0 ();
    bb_uart_txq_if #(.DATA_BITS(8)) if1 ();
    bb_uart_txq_if #(.DATA_BITS(8)) if2 ();
    bb_uart_txq_if #(.DATA_BITS(7)) if3 ();

    assign if0.wr_en = wr_en_v[0];  assign if0.wr_data = wr_data_v[0];
    assign if1.wr_en = wr_en_v[1];  assign if1.wr_data = wr_data_v[1];
    assign if2.wr_en = wr_en_v[2];  assign if2.wr_data = wr_data_v[2];
    assign if3.wr_en = wr_en_v[3];  assign if3.wr_data = wr_data_v[3][6:0];

    logic [3:0] txd_v, bsy_v, tick_v, full_v, empty_v, ovf_v;
    assign txd_v   = {if3.txd,     if2.txd,     if1.txd,     if0.txd};
    assign bsy_v   = {if3.txbsy,   if2.txbsy,   if1.txbsy,   if0.txbsy};
    assign tick_v  = {if3.bd_tick, if2.bd_tick, if1.bd_tick, if0.bd_tick};
    assign full_v  = {if3.full,    if2.full,    if1.full,    if0.full};
    assign empty_v = {if3.empty,   if2.empty,   if1.empty,   if0.empty};
    assign ovf_v   = {if3.ovf,     if2.ovf,     if1.ovf,     if0.ovf};

    bb_uart_txq #(.CLK_DIVIDER(DIV), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
        u_8n1 (.clk(clk), .nrst(nrst), .bus(if0));
    bb_uart_txq #(.CLK_DIVIDER(DIV), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4))
        u_8e1 (.clk(clk), .nrst(nrst), .bus(if1));
    bb_uart_txq #(.CLK_DIVIDER(DIV), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4))
        u_8o1 (.clk(clk), .nrst(nrst), .bus(if2));
    bb_uart_txq #(.CLK_DIVIDER(DIV), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4))
        u_7n2 (.clk(clk), .nrst(nrst), .bus(if3));

    typedef struct {
        int          dut;
        logic [15:0] bits;
        int          n;
    } frame_t;

    frame_t sb_q[$];
    int checks = 0;
    int errors = 0;

    // Reference frame: start, data LSB first, optional parity (counted ones), stop bits
    function automatic frame_t build_frame(input int dut, input logic [7:0] data);
        frame_t f;
        int db, par, sb, ones;
        case (dut)
            1:       begin db = 8; par = 2; sb = 1; end
            2:       begin db = 8; par = 1; sb = 1; end
            3:       begin db = 7; par = 0; sb = 2; end
            default: begin db = 8; par = 0; sb = 1; end
        endcase
        f.dut = dut; f.bits = '0; f.n = 0; ones = 0;
        f.bits[f.n] = 1'b0; f.n++;
        for (int i = 0; i < db; i++) begin
            f.bits[f.n] = data[i];
            ones += int'(data[i]);
            f.n++;
        end
        if (par == 2) begin f.bits[f.n] = ((ones % 2) == 1); f.n++; end
        if (par == 1) begin f.bits[f.n] = ((ones % 2) == 0); f.n++; end
        for (int i = 0; i < sb; i++) begin f.bits[f.n] = 1'b1; f.n++; end
        return f;
    endfunction

    // Present one write on the next edge; queue the expected frame if it should be accepted
    task automatic write(input int d, input logic [7:0] data, input bit accept);
        wr_en_v[d]   = 1'b1;
        wr_data_v[d] = data;
        if (accept) sb_q.push_back(build_frame(d, data));
        @(negedge clk);
        wr_en_v[d] = 1'b0;
    endtask

    task automatic wait_start(input int d, input int budget);
        for (int i = 0; i < budget && txd_v[d] !== 1'b0; i++) @(negedge clk);
        checks++;
        if (txd_v[d] !== 1'b0) begin
            errors++;
            $display("FAIL start_timeout dut%0d: txd=%b, required 0 within %0d cycles", d, txd_v[d], budget);
        end
    endtask

    // Pop the next expected frame and compare txd/txbsy every cycle of every bit time
    task automatic check_frame(input int d, input bit chk_empty, input logic exp_empty);
        frame_t f;
        int     ticks;
        bit     lvl_ok, bsy_ok;
        logic   lvl_act, emp0;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL sb_underflow dut%0d: frame observed, none expected", d);
            return;
        end
        f = sb_q.pop_front();
        checks++;
        if (f.dut != d) begin
            errors++;
            $display("FAIL sb_order: frame on dut%0d, expected dut%0d", d, f.dut);
        end
        emp0  = empty_v[d];
        ticks = 0;
        for (int b = 0; b < f.n; b++) begin
            lvl_ok = 1'b1; bsy_ok = 1'b1; lvl_act = f.bits[b];
            for (int c = 0; c < int'(DIV); c++) begin
                if (txd_v[d] !== f.bits[b]) begin lvl_ok = 1'b0; lvl_act = txd_v[d]; end
                if (bsy_v[d] !== 1'b1) bsy_ok = 1'b0;
                if (tick_v[d] === 1'b1) ticks++;
                @(negedge clk);
            end
            checks++;
            if (!lvl_ok) begin
                errors++;
                $display("FAIL frame_bit dut%0d bit%0d: txd=%b, required %b", d, b, lvl_act, f.bits[b]);
            end
            checks++;
            if (!bsy_ok) begin
                errors++;
                $display("FAIL frame_busy dut%0d bit%0d: txbsy dropped, required 1", d, b);
            end
        end
        checks++;
        if (ticks != f.n) begin
            errors++;
            $display("FAIL tick_count dut%0d: %0d ticks, required %0d", d, ticks, f.n);
        end
        if (chk_empty) begin
            checks++;
            if (emp0 !== exp_empty) begin
                errors++;
                $display("FAIL empty_at_pop dut%0d: empty=%b, required %b", d, emp0, exp_empty);
            end
        end
    endtask

    task automatic expect_idle(input int d, input string tag);
        checks++;
        if (bsy_v[d] !== 1'b0 || txd_v[d] !== 1'b1) begin
            errors++;
            $display("FAIL %s dut%0d: txbsy=%b txd=%b, required txbsy=0 txd=1", tag, d, bsy_v[d], txd_v[d]);
        end
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        wr_en_v = '0;
        for (int i = 0; i < 4; i++) wr_data_v[i] = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if (txd_v !== 4'hF || bsy_v !== 4'h0 || empty_v !== 4'hF) begin
            errors++;
            $display("FAIL reset_line: txd=%b txbsy=%b empty=%b, required 1111 0000 1111", txd_v, bsy_v, empty_v);
        end
        checks++;
        if (full_v !== 4'h0 || ovf_v !== 4'h0 || tick_v !== 4'h0) begin
            errors++;
            $display("FAIL reset_flags: full=%b ovf=%b bd_tick=%b, required 0000 0000 0000", full_v, ovf_v, tick_v);
        end
        nrst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_8n1();
        write(0, 8'h21, 1'b1);
        checks++;
        if (empty_v[0] !== 1'b0 || txd_v[0] !== 1'b1 || bsy_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL write_latency: empty=%b txd=%b txbsy=%b, required 0 1 0", empty_v[0], txd_v[0], bsy_v[0]);
        end
        @(negedge clk);
        checks++;
        if (txd_v[0] !== 1'b0 || bsy_v[0] !== 1'b1 || empty_v[0] !== 1'b1) begin
            errors++;
            $display("FAIL pop_latency: txd=%b txbsy=%b empty=%b, required 0 1 1", txd_v[0], bsy_v[0], empty_v[0]);
        end
        check_frame(0, 1'b0, 1'b0);
        expect_idle(0, "after_8n1");
    endtask

    task automatic test_parity();
        write(1, 8'h21, 1'b1);
        wait_start(1, 10);
        check_frame(1, 1'b0, 1'b0);
        expect_idle(1, "after_even");
        write(2, 8'h21, 1'b1);
        wait_start(2, 10);
        check_frame(2, 1'b0, 1'b0);
        expect_idle(2, "after_odd");
    endtask

    task automatic test_fifo_fill();
        fork
            begin
                for (int k = 1; k <= 6; k++) begin
                    write(0, 8'(k), k <= 5);
                    if (k == 5) begin
                        checks++;
                        if (full_v[0] !== 1'b1 || ovf_v[0] !== 1'b0) begin
                            errors++;
                            $display("FAIL full_after_5: full=%b ovf=%b, required 1 0", full_v[0], ovf_v[0]);
                        end
                    end
                    if (k == 6) begin
                        checks++;
                        if (ovf_v[0] !== 1'b1) begin
                            errors++;
                            $display("FAIL ovf_after_6: ovf=%b, required 1", ovf_v[0]);
                        end
                    end
                end
            end
            begin
                wait_start(0, 20);
                for (int f = 1; f <= 5; f++) check_frame(0, 1'b1, f == 5);
            end
        join
        expect_idle(0, "after_burst");
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d frames not seen, required 0", sb_q.size());
        end
    endtask

    task automatic test_7d2s();
        write(3, 8'h55, 1'b1);
        wait_start(3, 10);
        check_frame(3, 1'b0, 1'b0);
        expect_idle(3, "after_7n2");
    endtask

    task automatic test_reset_mid_frame();
        bit quiet;
        write(0, 8'hA5, 1'b1);
        write(0, 8'h3C, 1'b1);
        wait_start(0, 10);
        // start bit + data bits 0..2, then one cycle into data bit 3
        repeat (4 * DIV + 1) @(negedge clk);
        nrst = 1'b0;
        #1;
        checks++;
        if (txd_v[0] !== 1'b1 || bsy_v[0] !== 1'b0 || empty_v[0] !== 1'b1 || ovf_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_frame: txd=%b txbsy=%b empty=%b ovf=%b, required 1 0 1 0",
                     txd_v[0], bsy_v[0], empty_v[0], ovf_v[0]);
        end
        sb_q.delete();
        @(negedge clk);
        nrst = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (txd_v[0] !== 1'b1 || bsy_v[0] !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL post_reset_quiet: line active after reset, required txd=1 txbsy=0 for 100 cycles");
        end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_fifo_fill();
        test_7d2s();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
